// File: rtl/serial_bus_arbiter.sv
// Round-robin owner of a shared single-bit serial bus; grant registered one cycle after the REQ sample.
// Losing masters simply hold REQ; a started transfer (UTIL high) is never preempted.
module serial_bus_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [N_MASTERS-1:0] M_REQ,
    input  logic [N_MASTERS-1:0] M_UTIL,
    input  logic [N_MASTERS-1:0] M_RW,
    input  logic [N_MASTERS-1:0] M_ADD,
    input  logic [N_MASTERS-1:0] M_BUS_OUT,
    output logic [N_MASTERS-1:0] M_GRANT,
    output logic                 BUS_OUT,
    output logic                 BUS_RW,
    output logic                 BUS_ADD,
    output logic                 BUS_UTIL,
    output logic [2:0]           OWNER,
    output logic                 BUS_BUSY,
    output logic [15:0]          XFER_CNT
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           last_owner;
    logic [2:0]           winner;
    logic [2:0]           owner_nxt;
    logic [CW-1:0]        idle_cnt;
    logic [N_MASTERS-1:0] owner_mask;
    logic                 own_req;
    logic                 own_util;
    logic                 own_rw;
    logic                 own_add;
    logic                 own_out;
    logic                 other_req;
    logic                 any_req;
    logic                 timed_out;
    logic                 xfer_done;
    logic                 found;
    int                   cand;

    always_comb begin
        owner_mask = '0;
        own_req    = 1'b0;
        own_util   = 1'b0;
        own_rw     = 1'b0;
        own_add    = 1'b0;
        own_out    = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (OWNER == 3'(i)) begin
                owner_mask[i] = 1'b1;
                own_req       = M_REQ[i];
                own_util      = M_UTIL[i];
                own_rw        = M_RW[i];
                own_add       = M_ADD[i];
                own_out       = M_BUS_OUT[i];
            end
        end
    end

    assign other_req = |(M_REQ & ~owner_mask);
    assign any_req   = |M_REQ;
    assign timed_out = other_req && (idle_cnt == CNT_LAST);
    assign xfer_done = (state == BUSY) && !own_util;

    // Search starts just past the previous owner, so it gets lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = int'(last_owner) + k;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            for (int j = 0; j < N_MASTERS; j++) begin
                if (!found && (j == cand) && M_REQ[j]) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (own_util) begin
                    state_nxt = BUSY;
                end else if (!own_req || timed_out) begin
                    state_nxt = RELEASE;
                end
            end
            BUSY: begin
                if (!own_util) begin
                    state_nxt = own_req ? GRANT : RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUS_BUSY = (state == GRANT) || (state == BUSY);
        BUS_OUT  = BUS_BUSY & own_out;
        BUS_RW   = BUS_BUSY & own_rw;
        BUS_ADD  = BUS_BUSY & own_add;
        BUS_UTIL = BUS_BUSY & own_util;
    end

    assign owner_nxt = (state == IDLE && any_req) ? winner : OWNER;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            M_GRANT    <= '0;
            OWNER      <= '0;
            last_owner <= 3'(N_MASTERS - 1);
            idle_cnt   <= '0;
            XFER_CNT   <= '0;
        end else begin
            OWNER <= owner_nxt;
            if (state == IDLE && any_req) begin
                last_owner <= winner;
            end
            if (state_nxt == GRANT || state_nxt == BUSY) begin
                M_GRANT <= N_MASTERS'(1) << owner_nxt;
            end else begin
                M_GRANT <= '0;
            end
            // Only time spent idling on the grant while someone else waits counts.
            if (state == GRANT && state_nxt == GRANT && other_req) begin
                idle_cnt <= idle_cnt + CW'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (xfer_done && XFER_CNT != 16'hFFFF) begin
                XFER_CNT <= XFER_CNT + 16'd1;
            end
        end
    end

    assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(M_GRANT));
    assert property (@(posedge CLK) disable iff (!RSTN) int'(OWNER) < N_MASTERS);
    assert property (@(posedge CLK) disable iff (!RSTN) (state == BUSY && own_util) |-> (M_GRANT != '0));

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_serial_bus_arbiter;
    localparam int N  = 2;
    localparam int TO = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] util;
    logic [N-1:0] rw;
    logic [N-1:0] add;
    logic [N-1:0] bout;
    logic [N-1:0] grant;
    logic         bus_out;
    logic         bus_rw;
    logic         bus_add;
    logic         bus_util;
    logic [2:0]   owner;
    logic         bus_busy;
    logic [15:0]  xfer_cnt;

    int checks = 0;
    int passes = 0;

    serial_bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
        .CLK      (clk),
        .RSTN     (rstn),
        .M_REQ    (req),
        .M_UTIL   (util),
        .M_RW     (rw),
        .M_ADD    (add),
        .M_BUS_OUT(bout),
        .M_GRANT  (grant),
        .BUS_OUT  (bus_out),
        .BUS_RW   (bus_rw),
        .BUS_ADD  (bus_add),
        .BUS_UTIL (bus_util),
        .OWNER    (owner),
        .BUS_BUSY (bus_busy),
        .XFER_CNT (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (bitof(r, (last + k) % N)) return (last + k) % N;
        return -1;
    endfunction

    // Model: who holds the bus, whether a transfer is in flight, turnaround, wait time.
    int m_owner, m_last, m_wait, m_cnt;
    bit m_hold, m_xfer, m_gap;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_owner <= 0; m_last <= N - 1; m_wait <= 0; m_cnt <= 0;
            m_hold  <= 0; m_xfer <= 0;     m_gap  <= 0;
        end else if (m_gap) begin
            m_gap <= 0;
        end else if (!m_hold) begin
            if (rr_pick(req, m_last) >= 0) begin
                m_owner <= rr_pick(req, m_last);
                m_last  <= rr_pick(req, m_last);
                m_hold  <= 1; m_xfer <= 0; m_wait <= 0;
            end
        end else if (m_xfer) begin
            if (!bitof(util, m_owner)) begin
                m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_xfer <= 0; m_wait <= 0;
                if (!bitof(req, m_owner)) begin m_hold <= 0; m_gap <= 1; end
            end
        end else begin
            if (bitof(util, m_owner)) m_xfer <= 1;
            else if (!bitof(req, m_owner)) begin m_hold <= 0; m_gap <= 1; end
            else if ((req & ~(N'(1) << m_owner)) != '0) begin
                if (m_wait + 1 >= TO) begin m_hold <= 0; m_gap <= 1; m_wait <= 0; end
                else m_wait <= m_wait + 1;
            end else m_wait <= 0;
        end
    end

    always @(negedge clk) begin
        check("grant", grant, m_hold ? (N'(1) << m_owner) : '0);
        check("busy", bus_busy, m_hold);
        if (m_hold) check("owner", owner, m_owner);
        check("bus_out", bus_out, m_hold ? bitof(bout, m_owner) : 1'b0);
        check("bus_rw", bus_rw, m_hold ? bitof(rw, m_owner) : 1'b0);
        check("bus_add", bus_add, m_hold ? bitof(add, m_owner) : 1'b0);
        check("bus_util", bus_util, m_hold ? bitof(util, m_owner) : 1'b0);
        check("xfer_cnt", xfer_cnt, m_cnt);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 0; req = 0; util = 0; rw = 0; add = 0; bout = 0;
        cyc(2);
        rstn = 1;
        cyc(1);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 20) begin cyc(1); n++; end
    endtask

    initial begin
        int n;
        logic [N-1:0] eo;
        rstn = 0; req = 0; util = 0; rw = 0; add = 0; bout = 0;
        cyc(2);
        check("rst_grant", grant, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_xfer", xfer_cnt, 0);
        check("rst_mux", {bus_out, bus_rw, bus_add, bus_util}, 0);
        rstn = 1;
        cyc(1);

        // single request
        req = 2'b01;
        cyc(1);
        check("t1_grant", grant, 2'b01);
        check("t1_owner", owner, 0);
        util = 2'b01;
        cyc(20);
        check("t1_busy", {bus_busy, bus_util}, 2'b11);
        util = 0; req = 0;
        cyc(1);
        check("t1_xfer", xfer_cnt, 1);
        check("t1_rel", {grant, bus_busy}, 0);
        cyc(1);

        // contention round-robin
        do_reset();
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            eo = (t % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(n);
            if (t > 0) check("t2_gap", n, 2);
            check("t2_grant", grant, eo);
            util = eo;
            cyc(20);
            util = 0; req = 2'b11 & ~eo;
            cyc(1);
            check("t2_rel", grant, 0);
            req = 2'b11;
        end
        check("t2_xfer", xfer_cnt, 4);

        // no preemption
        do_reset();
        req = 2'b01; cyc(1);
        util = 2'b01; cyc(1);
        req = 2'b11; cyc(3);
        req = 2'b10;
        n = 0;
        for (int i = 0; i < 10; i++) begin cyc(1); if (grant == 2'b01) n++; end
        check("t3_hold", n, 10);
        util = 0; cyc(1);
        check("t3_rel", grant, 0);
        wait_grant(n);
        check("t3_gap", n, 2);
        check("t3_next", grant, 2'b10);

        // timeout with a waiter, then no timeout without one
        do_reset();
        req = 2'b11; cyc(1);
        check("t4_first", grant, 2'b01);
        n = 0;
        while (grant == 2'b01 && n < 200) begin cyc(1); n++; end
        check("t4_timeout", n, 32);
        wait_grant(n);
        check("t4_next", grant, 2'b10);
        do_reset();
        req = 2'b01; cyc(1);
        n = 0;
        for (int i = 0; i < 120; i++) begin if (grant == 2'b01) n++; cyc(1); end
        check("t4_keep", n, 120);

        // mux isolation
        do_reset();
        req = 2'b01; cyc(1);
        util = 2'b01; bout = 2'b01; rw = 2'b00; add = 2'b01; cyc(1);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            util[1] = i[0]; bout[1] = ~i[0]; rw[1] = i[1];
            cyc(1);
            if (bus_out === 1'b1 && bus_rw === 1'b0 && bus_add === 1'b1 && bus_util === 1'b1) n++;
        end
        check("t5_isolate", n, 16);
        bout[0] = 0; rw[0] = 1; #1;
        check("t5_follow", {bus_out, bus_rw}, 2'b01);
        util = 0; req = 0; cyc(2);
        util = 2'b11; rw = 2'b11; add = 2'b11; bout = 2'b11; cyc(1);
        check("t5_idle", {bus_out, bus_rw, bus_add, bus_util, bus_busy}, 0);
        util = 0; rw = 0; add = 0; bout = 0;

        // read-hold, then reset mid-transfer
        do_reset();
        req = 2'b01; cyc(1);
        util = 2'b01; cyc(3);
        util = 0; cyc(1);
        check("t6_rehold", grant, 2'b01);
        check("t6_cnt", xfer_cnt, 1);
        util = 2'b01; cyc(3);
        #2 rstn = 0;
        #1;
        check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", {bus_busy, bus_util}, 0);
        check("t6_rst_xfer", xfer_cnt, 0);
        req = 2'b11; util = 0;
        cyc(2);
        rstn = 1;
        wait_grant(n);
        check("t6_first", grant, 2'b01);
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
